// File: rtl/mem_arbiter_if.sv
// Bus bundle between the per-core requesters, the arbiter and the data memory.
// Optional MEM_ARB_LOCK_EN adds the per-core req_lock input.
interface mem_arbiter_if #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8
);
   logic [2*N_CORES-1:0]      req_ctrl;
   logic [ADDR_W*N_CORES-1:0] req_addr;
   logic [DATA_W*N_CORES-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
   logic [N_CORES-1:0]        req_lock;
`endif
   logic [N_CORES-1:0]        gnt;
   logic [N_CORES-1:0]        done;
   logic [DATA_W-1:0]         rdata;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_we;
   logic                      mem_re;
   logic [DATA_W-1:0]         mem_rdata;

   modport master (
`ifdef MEM_ARB_LOCK_EN
      input  req_lock,
`endif
      input  req_ctrl, req_addr, req_wdata, mem_rdata,
      output gnt, done, rdata, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport slave (
`ifdef MEM_ARB_LOCK_EN
      output req_lock,
`endif
      output req_ctrl, req_addr, req_wdata, mem_rdata,
      input  gnt, done, rdata, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing one data-memory access at a time among N_CORES cores.
// Define MEM_ARB_LOCK_EN to let a core hold the memory across accesses (read-modify-write).
module mem_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.master bus
);
   localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam logic [IW-1:0]      LAST_INIT = IW'(N_CORES - 1);
   localparam logic [N_CORES-1:0] ONE_HOT0  = {{(N_CORES-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE, S_LOCKED} state_t;

   state_t              state_r, state_s;
   logic [IW-1:0]       last_r, last_s, owner_r, owner_s;
   logic [IW-1:0]       win_idx_s, latch_idx_s, cand_s;
   logic                win_found_s, latch_en_s, is_read_r, is_read_s;
   logic [2:0]          cnt_r, cnt_s;
   logic [N_CORES-1:0]  valid_s, gnt_r, gnt_s, done_r, done_s;
   logic [DATA_W-1:0]   rdata_r, rdata_s, mem_wdata_r, mem_wdata_s;
   logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
   logic                mem_we_r, mem_we_s, mem_re_r, mem_re_s;
   logic [1:0]          ctrl_a  [N_CORES];
   logic [ADDR_W-1:0]   addr_a  [N_CORES];
   logic [DATA_W-1:0]   wdata_a [N_CORES];

   // Unpack per-core request fields; 2'b11 is reserved and counts as idle.
   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         ctrl_a[i]  = bus.req_ctrl[2*i +: 2];
         addr_a[i]  = bus.req_addr[ADDR_W*i +: ADDR_W];
         wdata_a[i] = bus.req_wdata[DATA_W*i +: DATA_W];
         valid_s[i] = (ctrl_a[i] == 2'b01) || (ctrl_a[i] == 2'b10);
      end
   end

   // Round-robin search starting just after the last winner.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int i = 1; i <= N_CORES; i++) begin
         cand_s = IW'((int'(last_r) + i) % N_CORES);
         if (!win_found_s && valid_s[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_s     = state_r;
      last_s      = last_r;
      owner_s     = owner_r;
      is_read_s   = is_read_r;
      cnt_s       = cnt_r;
      gnt_s       = gnt_r;
      done_s      = '0;
      rdata_s     = rdata_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      mem_we_s    = 1'b0;
      mem_re_s    = 1'b0;
      latch_en_s  = 1'b0;
      latch_idx_s = '0;

      case (state_r)
         S_IDLE: begin
            if (win_found_s) begin
               latch_en_s  = 1'b1;
               latch_idx_s = win_idx_s;
               last_s      = win_idx_s;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (is_read_r) begin
               state_s = S_WAIT;
               cnt_s   = 3'd0;
            end else begin
               state_s = S_DONE;
               done_s  = ONE_HOT0 << owner_r;
            end
         end
         S_WAIT: begin
            if (cnt_r == 3'(RD_LAT - 1)) begin
               rdata_s = bus.mem_rdata;
               done_s  = ONE_HOT0 << owner_r;
               state_s = S_DONE;
            end else begin
               cnt_s = cnt_r + 3'd1;
            end
         end
         S_DONE: begin
`ifdef MEM_ARB_LOCK_EN
            if (bus.req_lock[owner_r]) begin
               state_s = S_LOCKED;
            end else begin
               gnt_s   = '0;
               state_s = S_IDLE;
            end
`else
            gnt_s   = '0;
            state_s = S_IDLE;
`endif
         end
`ifdef MEM_ARB_LOCK_EN
         // Owner keeps the memory; its next request bypasses arbitration.
         S_LOCKED: begin
            if (valid_s[owner_r]) begin
               latch_en_s  = 1'b1;
               latch_idx_s = owner_r;
            end else if (!bus.req_lock[owner_r]) begin
               gnt_s   = '0;
               state_s = S_IDLE;
            end else begin
               state_s = S_LOCKED;
            end
         end
`endif
         default: begin
            gnt_s   = '0;
            state_s = S_IDLE;
         end
      endcase

      if (latch_en_s) begin
         state_s     = S_ACCESS;
         owner_s     = latch_idx_s;
         gnt_s       = ONE_HOT0 << latch_idx_s;
         is_read_s   = (ctrl_a[latch_idx_s] == 2'b01);
         mem_addr_s  = addr_a[latch_idx_s];
         mem_wdata_s = wdata_a[latch_idx_s];
         mem_re_s    = is_read_s;
         mem_we_s    = !is_read_s;
      end else begin
         owner_s = owner_s;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         last_r      <= LAST_INIT;
         owner_r     <= '0;
         is_read_r   <= 1'b0;
         cnt_r       <= 3'd0;
         gnt_r       <= '0;
         done_r      <= '0;
         rdata_r     <= '0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_we_r    <= 1'b0;
         mem_re_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         last_r      <= last_s;
         owner_r     <= owner_s;
         is_read_r   <= is_read_s;
         cnt_r       <= cnt_s;
         gnt_r       <= gnt_s;
         done_r      <= done_s;
         rdata_r     <= rdata_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         mem_we_r    <= mem_we_s;
         mem_re_r    <= mem_re_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.done      = done_r;
   assign bus.rdata     = rdata_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_re    = mem_re_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timeline model.
module tb_mem_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) mif ();
   mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .bus(mif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory responder: unwritten locations read back addr^A5, data appears RL cycles after mem_re.
   logic [7:0] env_mem [256];
   bit         env_wr  [256];
   logic [7:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (mif.mem_we) begin
         env_mem[mif.mem_addr[7:0]] <= mif.mem_wdata;
         env_wr[mif.mem_addr[7:0]]  <= 1'b1;
      end
      rd_pipe[0] <= !mif.mem_re ? 8'($urandom) :
                    env_wr[mif.mem_addr[7:0]] ? env_mem[mif.mem_addr[7:0]] :
                    (mif.mem_addr[7:0] ^ 8'hA5);
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mif.mem_rdata = rd_pipe[RL-1];

`ifdef MEM_ARB_LOCK_EN
   initial mif.req_lock = '0;
`endif

   // Requester agents and reference model state.
   logic [1:0]  a_ctrl  [N];
   logic [15:0] a_addr  [N];
   logic [7:0]  a_wdata [N];
   int          a_idle  [N];
   bit          a_drop  [N];
   int          wait_cnt[N];
   int          mode;            // 0 directed, 1 random, 2 continuous writes
   int          cyc = 0;
   bit          m_busy;
   int          m_T, m_end, m_idx, m_last;
   bit          m_rd;
   logic [15:0] m_addr;
   logic [7:0]  m_wd, m_rval, m_rdata;
   logic [7:0]  model_mem [256];
   logic [N-1:0] prev_gnt;
   int          order_q[$];

   function automatic bit is_valid(input logic [1:0] c);
      return (c == 2'b01) || (c == 2'b10);
   endfunction

   task automatic drive_bus();
      for (int k = 0; k < N; k++) begin
         mif.req_ctrl[2*k +: 2]     = a_ctrl[k];
         mif.req_addr[AW*k +: AW]   = a_addr[k];
         mif.req_wdata[DW*k +: DW]  = a_wdata[k];
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_last = N - 1; m_rdata = 8'h00; prev_gnt = '0;
      for (int k = 0; k < N; k++) begin
         a_ctrl[k] = 2'b00; a_addr[k] = 16'h0000; a_wdata[k] = 8'h00;
         a_idle[k] = 0; a_drop[k] = 1'b0; wait_cnt[k] = 0;
      end
   endtask

   task automatic post(input int k, input logic [1:0] c, input logic [15:0] a, input logic [7:0] w);
      a_ctrl[k] = c; a_addr[k] = a; a_wdata[k] = w;
   endtask

   task automatic step();
      int d, gi, r;
      logic [N-1:0] eg, ed;
      logic ewe, ere;
      @(posedge clk); #1;
      cyc++;
      eg = '0; ed = '0; ewe = 1'b0; ere = 1'b0; d = -1;
      if (m_busy) begin
         d = cyc - m_T;
         if (d >= 1 && d <= m_end) eg[m_idx] = 1'b1;
         if (d == m_end) begin
            ed = eg;
            if (m_rd) m_rdata = m_rval;
         end
         if (d == 1) begin
            ewe = !m_rd; ere = m_rd;
            if (!m_rd) model_mem[m_addr[7:0]] = m_wd;
         end
      end
      check_eq("gnt", mif.gnt, eg);
      check_eq("done", mif.done, ed);
      check_eq("mem_we", mif.mem_we, ewe);
      check_eq("mem_re", mif.mem_re, ere);
      check_eq("rdata", mif.rdata, m_rdata);
      if (d == 1) begin
         check_eq("mem_addr", mif.mem_addr, m_addr);
         if (!m_rd) check_eq("mem_wdata", mif.mem_wdata, m_wd);
      end
      // Grant order and starvation bound observed on the DUT.
      if (mif.gnt != '0 && prev_gnt == '0) begin
         gi = 0;
         for (int k = 0; k < N; k++) if (mif.gnt[k]) gi = k;
         order_q.push_back(gi);
         check_eq("starve_bound", wait_cnt[gi], (wait_cnt[gi] <= N - 1) ? wait_cnt[gi] : N - 1);
         wait_cnt[gi] = 0;
         for (int k = 0; k < N; k++) if (k != gi && is_valid(a_ctrl[k])) wait_cnt[k]++;
      end
      prev_gnt = mif.gnt;
      for (int k = 0; k < N; k++) begin
         if (a_drop[k]) begin
            a_ctrl[k] = 2'b00; a_drop[k] = 1'b0;
            a_idle[k] = (mode == 2) ? 0 : int'($urandom_range(0, 4));
         end else if (is_valid(a_ctrl[k])) begin
            if (mode == 1 && m_busy && m_idx == k && d >= 1) begin
               a_addr[k] = 16'($urandom); a_wdata[k] = 8'($urandom);
            end
         end else if (mode != 0) begin
            if (a_idle[k] > 0) a_idle[k]--;
            else begin
               r = (mode == 2) ? 7 : int'($urandom_range(0, 7));
               a_ctrl[k]  = (r == 0) ? 2'b11 : (r < 4) ? 2'b01 : 2'b10;
               a_addr[k]  = {8'($urandom), 1'b0, 7'($urandom)};
               a_wdata[k] = 8'($urandom);
            end
         end
      end
      if (ed != '0) a_drop[m_idx] = 1'b1;
      drive_bus();
      if (m_busy && cyc > m_T + m_end) m_busy = 1'b0;
      if (!m_busy) begin
         for (int i = 1; i <= N && !m_busy; i++) begin
            gi = (m_last + i) % N;
            if (is_valid(a_ctrl[gi])) begin
               m_busy = 1'b1; m_T = cyc; m_idx = gi; m_last = gi;
               m_rd   = (a_ctrl[gi] == 2'b01);
               m_end  = m_rd ? 2 + RL : 2;
               m_addr = a_addr[gi]; m_wd = a_wdata[gi];
               m_rval = model_mem[a_addr[gi][7:0]];
            end
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         bit busy_any;
         busy_any = m_busy;
         for (int k = 0; k < N; k++) if (a_ctrl[k] != 2'b00 || a_drop[k]) busy_any = 1'b1;
         if (!busy_any) break;
         step();
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_gnt"}, mif.gnt, 0);
      check_eq({tag, "_done"}, mif.done, 0);
      check_eq({tag, "_rdata"}, mif.rdata, 0);
      check_eq({tag, "_addr"}, mif.mem_addr, 0);
      check_eq({tag, "_wdata"}, mif.mem_wdata, 0);
      check_eq({tag, "_we"}, mif.mem_we, 0);
      check_eq({tag, "_re"}, mif.mem_re, 0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) model_mem[a] = 8'(a) ^ 8'hA5;
      mode = 0;
      rst  = 1'b1;
      model_reset();
      drive_bus();
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      #2 rst = 1'b0;

      // Every core writes back-to-back from reset: order 0,1,2,3,0.
      mode = 2;
      order_q.delete();
      repeat (30) step();
      for (int i = 0; i < 5; i++)
         check_eq("rr_order", (order_q.size() > i) ? order_q[i] : 99, i % N);
      mode = 0;
      drain();

      // Single write from core1.
      post(1, 2'b10, 16'h0010, 8'h5A);
      repeat (6) step();
      check_eq("wr_mem", env_mem[8'h10], 8'h5A);

      // Single read from core2; memory returns 0x3C.
      post(2, 2'b01, 16'h0099, 8'h00);
      repeat (8) step();
      check_eq("rd_3c", mif.rdata, 8'h3C);

      // Reserved code on core0 while core3 reads.
      order_q.delete();
      post(0, 2'b11, 16'h0001, 8'h11);
      post(3, 2'b01, 16'h0005, 8'h00);
      repeat (10) step();
      check_eq("rsv_grants", order_q.size(), 1);
      check_eq("rsv_winner", (order_q.size() > 0) ? order_q[0] : 99, 3);
      post(0, 2'b00, 16'h0000, 8'h00);
      drain();

      // Reset in the middle of a read's WAIT phase.
      post(2, 2'b01, 16'h0099, 8'h00);
      for (int i = 0; i < 10; i++) begin
         if (m_busy && (cyc - m_T) == 2) break;
         step();
      end
      check_eq("wait_reached", mif.mem_re | (mif.gnt == 4'b0100), 1);
      #2 rst = 1'b1;
      #1 check_outputs_zero("midrst");
      model_reset();
      drive_bus();
      @(posedge clk);
      #3 rst = 1'b0;
      order_q.delete();
      for (int k = 0; k < N; k++) post(k, 2'b10, 16'(16 + k), 8'(k + 1));
      repeat (4) step();
      check_eq("first_after_rst", (order_q.size() > 0) ? order_q[0] : 99, 0);
      drain();

      // Random traffic.
      mode = 1;
      repeat (3000) step();
      mode = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
